// File: rtl/qmult_r4.sv
// Radix-4 Booth sequential multiplier with an optional result accumulator.
// Latency: product_dout_vld pulses K+1 edges after accept (K = Booth digits processed, 0..N/2+1), plus any ce=0 stalls.
// Backpressure: in_rdy is high only in IDLE; in_vld while busy is ignored and operands are never queued.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ce                       clock enable; low freezes state (reset still acts)
//   in_vld / in_rdy          operand handshake; accept = IDLE & ce & in_vld
//   signed_mode              1 = two's complement operands (sampled at accept)
//   acc_mode, clr_acc        accumulate / clear controls (only with QMULT_R4_ACC_EN)
//   multiplicand_din (A)     N-bit operand
//   multiplier_din   (B)     N-bit operand
//   product_dout             OUT_W-bit result, held until the next result or reset
//   product_dout_vld         one-cycle pulse on a new product_dout
//   busy                     high while in RUN
// Build option: define QMULT_R4_ACC_EN to include the accumulator.
module qmult_r4 #(
  parameter int N     = 8,   // even, 4..32
  parameter int OUT_W = 32   // 2N..64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             signed_mode,
  input  logic             acc_mode,
  input  logic             clr_acc,
  input  logic [N-1:0]     multiplicand_din,
  input  logic [N-1:0]     multiplier_din,
  output logic [OUT_W-1:0] product_dout,
  output logic             product_dout_vld,
  output logic             busy
);

  // Partial-sum width: 2N product bits plus headroom for the +/-2A terms.
  localparam int W  = 2 * N + 2;
  // Multiplier register {ext, ext, B, 0}.
  localparam int MW = N + 3;
  localparam int CW = $clog2(N / 2 + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N / 2 + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;        // +A, shifted left 2 per digit
  logic [W-1:0]     na_q, na_d;      // -A, shifted left 2 per digit
  logic [W-1:0]     psum_q, psum_d;
  logic [MW-1:0]    mreg_q, mreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;

  logic             accept;
  logic             stop;
  logic [W-1:0]     a_ext;
  logic             b_ext;
  logic [W-1:0]     term;
  logic [OUT_W-1:0] result;
  logic             unused_bits;

  assign accept = (state_q == IDLE) && ce && in_vld;

  // Once mreg is all-zeros or all-ones every remaining Booth digit is zero,
  // so the loop can end early. The counter bound is the worst case.
  assign stop = (mreg_q == '0) || (mreg_q == '1) || (cnt_q == CNT_LAST);

  assign a_ext = signed_mode ? {{(N + 2){multiplicand_din[N-1]}}, multiplicand_din}
                             : {{(N + 2){1'b0}}, multiplicand_din};
  assign b_ext = signed_mode & multiplier_din[N-1];

  // Radix-4 Booth digit select from the low triplet of mreg.
  always_comb begin
    term = '0;
    case (mreg_q[2:0])
      3'b001, 3'b010: term = a_q;
      3'b011:         term = {a_q[W-2:0], 1'b0};
      3'b100:         term = {na_q[W-2:0], 1'b0};
      3'b101, 3'b110: term = na_q;
      default:        term = '0;
    endcase
  end

  // The exact product fits in 2N bits; extend it by the latched mode.
  assign result = sgn_q ? OUT_W'($signed(psum_q[2*N-1:0]))
                        : OUT_W'(psum_q[2*N-1:0]);

`ifdef QMULT_R4_ACC_EN
  logic             accm_q, accm_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] acc_new;

  // A clear coinciding with a result write leaves just the result.
  assign acc_new = clr_acc ? result : (accm_q ? acc_q + result : result);
  assign unused_bits = ^psum_q[W-1:2*N];
`else
  assign unused_bits = ^{psum_q[W-1:2*N], acc_mode, clr_acc};
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    na_d    = na_q;
    psum_d  = psum_q;
    mreg_d  = mreg_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    dout_d  = dout_q;
    // The valid flag is a pulse, so it drops on every edge, including ce=0 edges.
    vld_d   = 1'b0;
`ifdef QMULT_R4_ACC_EN
    accm_d  = accm_q;
    acc_d   = acc_q;
    if (ce && clr_acc) acc_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_ext;
          na_d    = -a_ext;
          mreg_d  = {b_ext, b_ext, multiplier_din, 1'b0};
          cnt_d   = '0;
          psum_d  = '0;
          sgn_d   = signed_mode;
`ifdef QMULT_R4_ACC_EN
          accm_d  = acc_mode;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        if (ce) begin
          if (stop) begin
            vld_d   = 1'b1;
            state_d = IDLE;
`ifdef QMULT_R4_ACC_EN
            acc_d   = acc_new;
            dout_d  = acc_new;
`else
            dout_d  = result;
`endif
          end else begin
            psum_d = psum_q + term;
            a_d    = a_q << 2;
            na_d   = na_q << 2;
            mreg_d = {{2{mreg_q[MW-1]}}, mreg_q[MW-1:2]};
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      na_q    <= '0;
      psum_q  <= '0;
      mreg_q  <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
`ifdef QMULT_R4_ACC_EN
      accm_q  <= 1'b0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      na_q    <= na_d;
      psum_q  <= psum_d;
      mreg_q  <= mreg_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
`ifdef QMULT_R4_ACC_EN
      accm_q  <= accm_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign in_rdy           = (state_q == IDLE);
  assign busy             = (state_q == RUN);
  assign product_dout     = dout_q;
  assign product_dout_vld = vld_q;

endmodule
